// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  // Default widths of the command bus.
  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 16;

  // Memory may acknowledge no earlier than this many cycles after mem_en.
  localparam int unsigned MIN_MEM_LAT = 1;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  // One memory command at the default widths.
  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/arb_select.sv
// rtl/arb_select.sv - combinational winner picker; MEM_ARB_ROUND_ROBIN_EN selects round-robin
module arb_select #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic [IDX_W-1:0]   ptr,
  input  logic               ptr_vld,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  logic [NUM_REQ-1:0] cand;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Round-robin: search from the slot after the last winner, wrapping to 0.
  always_comb begin
    int start;
    int idx;
    logic found;
    cand      = req & ~mask;
    grant     = '0;
    grant_idx = '0;
    any       = |cand;
    found     = 1'b0;
    start     = ptr_vld ? ((int'(ptr) + 1) % NUM_REQ) : 0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (start + k) % NUM_REQ;
      if (!found && cand[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end
`else
  // Fixed priority: scanning downward leaves the lowest requesting index as winner.
  always_comb begin
    cand      = req & ~mask;
    grant     = '0;
    grant_idx = '0;
    any       = |cand;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - N-requester arbiter onto one memory port; MEM_ARB_ROUND_ROBIN_EN enables round-robin
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        stall,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_ack,
  input  logic [DATA_W-1:0]         mem_rdata
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
  cmd_t                cmd_q, cmd_d;
  logic                mem_en_q, mem_en_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [NUM_REQ-1:0]  sel_grant;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_any;
  cmd_t                sel_cmd;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic                ptr_vld_q, ptr_vld_d;
`endif

  // A requester's own done cycle masks it, so a held req is not regranted.
  arb_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb_select (
    .req       (req),
    .mask      (done_q),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .ptr       (ptr_q),
    .ptr_vld   (ptr_vld_q),
`endif
    .grant     (sel_grant),
    .grant_idx (sel_idx),
    .any       (sel_any)
  );

  // Mux the winning requester's command using the one-hot grant.
  always_comb begin
    sel_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_grant[i]) begin
        sel_cmd.we    = req_we[i];
        sel_cmd.addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_cmd.wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state logic: arbitrate in IDLE, strobe in ISSUE, hold until ack in WAIT.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    cmd_d       = cmd_q;
    mem_en_d    = 1'b0;
    done_d      = '0;
    rdata_d     = rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    ptr_d       = ptr_q;
    ptr_vld_d   = ptr_vld_q;
`endif
    case (state_q)
      IDLE: begin
        if (sel_any) begin
          state_d     = ISSUE;
          grant_idx_d = sel_idx;
          cmd_d       = sel_cmd;
          mem_en_d    = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          ptr_d       = sel_idx;
          ptr_vld_d   = 1'b1;
`endif
        end
      end
      ISSUE: begin
        // Ack is not accepted here: memory needs at least one cycle after mem_en.
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_ack) begin
          state_d             = IDLE;
          done_d[grant_idx_q] = 1'b1;
          rdata_d             = cmd_q.we ? '0 : mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; asynchronous reset returns everything to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
      cmd_q       <= '0;
      mem_en_q    <= 1'b0;
      done_q      <= '0;
      rdata_q     <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_q       <= '0;
      ptr_vld_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      cmd_q       <= cmd_d;
      mem_en_q    <= mem_en_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_q       <= ptr_d;
      ptr_vld_q   <= ptr_vld_d;
`endif
    end
  end

  assign stall     = req & ~done_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;

  // The granted requester must keep req high until its done pulse.
  assert property (@(posedge clk) disable iff (!rst_n)
                   (state_q != IDLE) |-> req[grant_idx_q]);

  // The command strobe is followed by the ack-accepting state after the minimum latency.
  assert property (@(posedge clk) disable iff (!rst_n)
                   mem_en_q |-> ##MIN_MEM_LAT (state_q == WAIT));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter; honours MEM_ARB_ROUND_ROBIN_EN
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int NR = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req, req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    stall, done;
  logic [DW-1:0]    rdata;
  logic             mem_en, mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic             mem_ack;
  logic [DW-1:0]    mem_rdata;

  int vectors     = 0;
  int miscompares = 0;

  mem_port_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .IDX_W   (IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .stall     (stall),
    .done      (done),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic idle_inputs();
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]              = 1'b1;
    req_we[i]           = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    req = 4'b0101;
    repeat (2) @(negedge clk);
    vectors++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, done, rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got en=%b we=%b addr=%h wdata=%h done=%b rdata=%h, expected all zero",
               mem_en, mem_we, mem_addr, mem_wdata, done, rdata);
    end
    vectors++;
    if (stall !== 4'b0101) begin
      miscompares++;
      $display("FAIL reset_stall: got %b expected 0101", stall);
    end
    req = '0;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({mem_en, done} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_release_idle: got en=%b done=%b expected 0/0000", mem_en, done);
    end
  endtask

  task automatic test_single_read();
    mem_cmd_t exp;
    set_req(1, 1'b0, 16'h0040, 16'h0000);
    @(negedge clk);
    exp = '{we: 1'b0, addr: 16'h0040, wdata: 16'h0000};
    vectors++;
    if (mem_en !== 1'b1 || {mem_we, mem_addr, mem_wdata} !== exp) begin
      miscompares++;
      $display("FAIL single_read_issue: got en=%b cmd=%h expected en=1 cmd=%h", mem_en, {mem_we, mem_addr, mem_wdata}, exp);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors++;
      if ({mem_en, done, stall} !== {1'b0, 4'b0000, 4'b0010} || mem_addr !== 16'h0040) begin
        miscompares++;
        $display("FAIL single_read_wait: got en=%b done=%b stall=%b addr=%h expected 0/0000/0010/0040", mem_en, done, stall, mem_addr);
      end
    end
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 16'hBEEF;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    vectors++;
    if (done !== 4'b0010 || rdata !== 16'hBEEF || stall !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_read_done: got done=%b rdata=%h stall=%b expected 0010/beef/0000", done, rdata, stall);
    end
    req = '0;
    @(negedge clk);
    vectors++;
    if ({mem_en, done} !== 5'b0) begin
      miscompares++;
      $display("FAIL single_read_after: got en=%b done=%b expected 0/0000", mem_en, done);
    end
  endtask

  task automatic test_simultaneous();
    mem_cmd_t exp;
    set_req(0, 1'b1, 16'h0010, 16'h1234);
    set_req(1, 1'b0, 16'h0020, 16'h0000);
    @(negedge clk);
    exp = '{we: 1'b1, addr: 16'h0010, wdata: 16'h1234};
    vectors++;
    if (mem_en !== 1'b1 || {mem_we, mem_addr, mem_wdata} !== exp || stall !== 4'b0011) begin
      miscompares++;
      $display("FAIL simul_first_issue: got en=%b cmd=%h stall=%b expected 1/%h/0011", mem_en, {mem_we, mem_addr, mem_wdata}, stall, exp);
    end
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 16'h5555;
    @(negedge clk);
    mem_ack   = 1'b0;
    vectors++;
    if (done !== 4'b0001 || rdata !== 16'h0000 || mem_en !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_first_done: got done=%b rdata=%h en=%b expected 0001/0000/0", done, rdata, mem_en);
    end
    req[0] = 1'b0;
    @(negedge clk);
    exp = '{we: 1'b0, addr: 16'h0020, wdata: 16'h0000};
    vectors++;
    if (mem_en !== 1'b1 || {mem_we, mem_addr, mem_wdata} !== exp || done !== 4'b0000) begin
      miscompares++;
      $display("FAIL simul_second_issue: got en=%b cmd=%h done=%b expected 1/%h/0000", mem_en, {mem_we, mem_addr, mem_wdata}, done, exp);
    end
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 16'h0A0A;
    @(negedge clk);
    mem_ack   = 1'b0;
    vectors++;
    if (done !== 4'b0010 || rdata !== 16'h0A0A) begin
      miscompares++;
      $display("FAIL simul_second_done: got done=%b rdata=%h expected 0010/0a0a", done, rdata);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_lock();
    mem_cmd_t exp;
    set_req(1, 1'b0, 16'h0300, 16'h0000);
    @(negedge clk);
    vectors++;
    if (mem_en !== 1'b1 || mem_addr !== 16'h0300) begin
      miscompares++;
      $display("FAIL lock_issue: got en=%b addr=%h expected 1/0300", mem_en, mem_addr);
    end
    @(negedge clk);
    set_req(0, 1'b1, 16'h0100, 16'h7777);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      exp = '{we: 1'b0, addr: 16'h0300, wdata: 16'h0000};
      vectors++;
      if (mem_en !== 1'b0 || {mem_we, mem_addr, mem_wdata} !== exp || stall !== 4'b0011) begin
        miscompares++;
        $display("FAIL lock_hold: got en=%b cmd=%h stall=%b expected 0/%h/0011", mem_en, {mem_we, mem_addr, mem_wdata}, stall, exp);
      end
    end
    mem_ack   = 1'b1;
    mem_rdata = 16'h1357;
    @(negedge clk);
    mem_ack   = 1'b0;
    vectors++;
    if (done !== 4'b0010 || rdata !== 16'h1357) begin
      miscompares++;
      $display("FAIL lock_first_done: got done=%b rdata=%h expected 0010/1357", done, rdata);
    end
    req[1] = 1'b0;
    @(negedge clk);
    exp = '{we: 1'b1, addr: 16'h0100, wdata: 16'h7777};
    vectors++;
    if (mem_en !== 1'b1 || {mem_we, mem_addr, mem_wdata} !== exp) begin
      miscompares++;
      $display("FAIL lock_next_issue: got en=%b cmd=%h expected 1/%h", mem_en, {mem_we, mem_addr, mem_wdata}, exp);
    end
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    vectors++;
    if (done !== 4'b0001 || rdata !== 16'h0000) begin
      miscompares++;
      $display("FAIL lock_next_done: got done=%b rdata=%h expected 0001/0000", done, rdata);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_ack_in_issue();
    set_req(2, 1'b0, 16'h0555, 16'h0000);
    @(negedge clk);
    vectors++;
    if (mem_en !== 1'b1) begin
      miscompares++;
      $display("FAIL ack_issue_en: got en=%b expected 1", mem_en);
    end
    mem_ack   = 1'b1;
    mem_rdata = 16'hDEAD;
    @(negedge clk);
    mem_ack   = 1'b0;
    vectors++;
    if (done !== 4'b0000 || mem_en !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_issue_ignored: got done=%b en=%b expected 0000/0", done, mem_en);
    end
    @(negedge clk);
    vectors++;
    if (done !== 4'b0000 || mem_addr !== 16'h0555 || stall !== 4'b0100) begin
      miscompares++;
      $display("FAIL ack_issue_still_wait: got done=%b addr=%h stall=%b expected 0000/0555/0100", done, mem_addr, stall);
    end
    mem_ack   = 1'b1;
    mem_rdata = 16'h1111;
    @(negedge clk);
    mem_ack   = 1'b0;
    vectors++;
    if (done !== 4'b0100 || rdata !== 16'h1111) begin
      miscompares++;
      $display("FAIL ack_issue_late_done: got done=%b rdata=%h expected 0100/1111", done, rdata);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    set_req(3, 1'b1, 16'h0ABC, 16'h4444);
    @(negedge clk);
    vectors++;
    if (mem_en !== 1'b1 || mem_addr !== 16'h0ABC) begin
      miscompares++;
      $display("FAIL rst_wait_issue: got en=%b addr=%h expected 1/0abc", mem_en, mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    #1;
    vectors++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, done, rdata} !== '0) begin
      miscompares++;
      $display("FAIL rst_wait_async: got en=%b we=%b addr=%h wdata=%h done=%b rdata=%h expected all zero",
               mem_en, mem_we, mem_addr, mem_wdata, done, rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 16'hFFFF;
    @(negedge clk);
    mem_ack   = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({mem_en, mem_we, mem_addr, mem_wdata, done, rdata} !== '0) begin
        miscompares++;
        $display("FAIL rst_wait_stray_ack: got en=%b we=%b addr=%h wdata=%h done=%b rdata=%h expected all zero",
                 mem_en, mem_we, mem_addr, mem_wdata, done, rdata);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int       exp_seq[5];
    bit       ok;
    logic [NR-1:0] exp_done;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 2, 3, 0};
`else
    exp_seq = '{0, 1, 0, 1, 0};
`endif
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 16'h1000 + 16'(i), 16'h0000);
    for (int t = 0; t < 5; t++) begin
      ok = 1'b0;
      for (int w = 0; w < 10; w++) begin
        @(negedge clk);
        if (mem_en === 1'b1) begin
          ok = 1'b1;
          break;
        end
      end
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL b2b_timeout: transaction %0d got no mem_en within 10 cycles, expected one", t);
        break;
      end
      vectors++;
      if (mem_addr !== 16'h1000 + 16'(exp_seq[t])) begin
        miscompares++;
        $display("FAIL b2b_grant: transaction %0d got addr=%h expected %h", t, mem_addr, 16'h1000 + 16'(exp_seq[t]));
      end
      @(negedge clk);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      exp_done = NR'(1) << exp_seq[t];
      vectors++;
      if (done !== exp_done) begin
        miscompares++;
        $display("FAIL b2b_done: transaction %0d got done=%b expected %b", t, done, exp_done);
      end
      if (t == 4) req = '0;
    end
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_lock();
    test_ack_in_issue();
    test_reset_mid_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
